// File: rtl/collect_2x1_rr_seq_pkg.sv
// collect_2x1_rr_seq_pkg: command and source encodings shared by the collect switch.
package collect_2x1_rr_seq_pkg;
    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_LOW  = 2'b01;
    localparam logic [1:0] CMD_HIGH = 2'b10;
    localparam logic [1:0] CMD_BOTH = 2'b11;
    localparam logic SRC_LOW  = 1'b0;
    localparam logic SRC_HIGH = 1'b1;
endpackage

// File: rtl/sync_fifo_simple_seq.sv
// sync_fifo_simple_seq: single-clock FIFO; pushes when full and pops when empty are ignored.
module sync_fifo_simple_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic do_push, do_pop;
    assign full  = count_q == CW'(FIFO_DEPTH);
    assign empty = count_q == '0;
    assign dout  = mem_q[rd_ptr_q];
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/collect_2x1_rr_seq.sv
// collect_2x1_rr_seq: merges two buffered branches onto one registered valid/ready output,
// round-robin between branches when both are eligible.
module collect_2x1_rr_seq
    import collect_2x1_rr_seq_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int COMMAND_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               i_valid,
    input  logic [2*DATA_WIDTH-1:0]  i_data_bus,
    output logic [1:0]               o_ready,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_data_bus,
    output logic                     o_src,
    input  logic                     i_ready,
    input  logic                     i_en,
    input  logic [COMMAND_WIDTH-1:0] i_cmd
);
    logic [1:0] full, empty, pop, eligible;
    logic [DATA_WIDTH-1:0] head [2];
    logic grant, load;
    logic o_valid_q, o_valid_d, o_src_q, o_src_d, last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    for (genvar k = 0; k < 2; k++) begin : g_fifo
        sync_fifo_simple_seq #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (i_valid[k] & o_ready[k]),
            .pop   (pop[k]),
            .din   (i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
            .dout  (head[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end
    // Ready depends only on stored counts (and reset), never on i_ready.
    assign o_ready    = ~full & {2{~rst}};
    assign o_valid    = o_valid_q;
    assign o_data_bus = o_data_q;
    assign o_src      = o_src_q;
    always_comb begin
        eligible     = i_cmd[1:0] & ~empty;
        grant        = (eligible == CMD_BOTH) ? ~last_grant_q : (eligible[1] ? SRC_HIGH : SRC_LOW);
        load         = i_en & (~o_valid_q | i_ready) & (|eligible);
        pop          = load ? (grant ? 2'b10 : 2'b01) : 2'b00;
        o_valid_d    = load | (o_valid_q & ~i_ready);
        o_data_d     = load ? head[grant] : o_data_q;
        o_src_d      = load ? grant : o_src_q;
        last_grant_d = load ? grant : last_grant_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q    <= 1'b0;
            o_data_q     <= '0;
            o_src_q      <= SRC_LOW;
            last_grant_q <= SRC_HIGH;
        end else begin
            o_valid_q    <= o_valid_d;
            o_data_q     <= o_data_d;
            o_src_q      <= o_src_d;
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: tb/tb_collect_2x1_rr_seq.sv
// tb_collect_2x1_rr_seq: directed test-plan steps plus random traffic against a queue-based model.
module tb_collect_2x1_rr_seq;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst, o_valid, o_src, i_ready, i_en;
    logic [1:0] i_valid, o_ready, i_cmd;
    logic [63:0] i_data_bus;
    logic [31:0] o_data_bus;
    int errors = 0;
    int checks = 0;
    bit live = 0;
    logic [31:0] q0[$], q1[$], got[$], exp_q[$];
    logic m_ov = 0, m_os = 0, m_lg = 1;
    logic [31:0] m_od = 0;

    collect_2x1_rr_seq #(.DATA_WIDTH(32), .FIFO_DEPTH(D), .COMMAND_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .o_ready(o_ready),
        .o_valid(o_valid), .o_data_bus(o_data_bus), .o_src(o_src), .i_ready(i_ready),
        .i_en(i_en), .i_cmd(i_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    // One clock cycle: drive, check the visible outputs against the model, advance the model.
    task automatic cyc(input logic r, input logic [1:0] v, input logic [31:0] dl, input logic [31:0] dh,
                       input logic en, input logic [1:0] cmd, input logic rdy);
        bit p0, p1, e0, e1, ld, g;
        rst = r; i_valid = v; i_data_bus = {dh, dl}; i_en = en; i_cmd = cmd; i_ready = rdy;
        #1;
        if (live) begin
            chk("o_valid", o_valid, m_ov);
            if (m_ov || r) begin
                chk("o_data_bus", o_data_bus, m_od);
                chk("o_src", o_src, m_os);
            end
            chk("o_ready", o_ready, r ? 2'b00 : {q1.size() < D, q0.size() < D});
        end
        if (o_valid && rdy && !r) got.push_back(o_data_bus);
        if (r) begin
            q0.delete(); q1.delete();
            m_lg = 1; m_ov = 0; m_od = 0; m_os = 0;
        end else begin
            p0 = v[0] && q0.size() < D;
            p1 = v[1] && q1.size() < D;
            e0 = cmd[0] && q0.size() > 0;
            e1 = cmd[1] && q1.size() > 0;
            ld = en && (!m_ov || rdy) && (e0 || e1);
            g  = (e0 && e1) ? !m_lg : e1;
            if (ld) begin
                m_od = g ? q1.pop_front() : q0.pop_front();
                m_ov = 1; m_os = g; m_lg = g;
            end else if (m_ov && rdy) m_ov = 0;
            if (p0) q0.push_back(dl);
            if (p1) q1.push_back(dh);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        cyc(1, 2'b11, 1, 2, 1, 2'b11, 1);
        live = 1;
        cyc(1, 2'b11, 1, 2, 1, 2'b11, 1);
        cyc(0, 2'b00, 0, 0, 1, 2'b11, 1);
        chk("reset_idle_count", got.size(), 0);
        got.delete();
        // single branch
        cyc(0, 2'b01, 32'hA, 0, 1, 2'b01, 1);
        cyc(0, 2'b00, 0, 0, 1, 2'b01, 1);
        #1 chk("single_data", o_data_bus, 32'hA);
        for (int i = 0; i < 3; i++) cyc(0, 2'b00, 0, 0, 1, 2'b01, 1);
        exp_q = '{32'hA};
        chk_seq("single_seq");
        // round-robin from a fresh pointer
        cyc(1, 2'b00, 0, 0, 1, 2'b11, 1);
        got.delete();
        for (int i = 1; i <= 3; i++) cyc(0, 2'b11, i, 32'h10 + i, 1, 2'b11, 1);
        for (int i = 0; i < 7; i++) cyc(0, 2'b00, 0, 0, 1, 2'b11, 1);
        exp_q = '{32'h1, 32'h11, 32'h2, 32'h12, 32'h3, 32'h13};
        chk_seq("rr_seq");
        // backpressure
        for (int i = 0; i < 6; i++) cyc(0, 2'b01, i, 0, 1, 2'b01, 0);
        #1 chk("bp_ready_low", o_ready[0], 1'b0);
        chk("bp_head_held", o_data_bus, 32'h0);
        for (int i = 0; i < 8; i++) cyc(0, 2'b00, 0, 0, 1, 2'b01, 1);
        exp_q = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4};
        chk_seq("bp_seq");
        // masking
        for (int i = 0; i < 5; i++) cyc(0, 2'b10, 0, 32'h20 + i, 1, 2'b01, 1);
        #1 chk("mask_ready_high", o_ready[1], 1'b0);
        chk("mask_no_output", got.size(), 0);
        for (int i = 0; i < 8; i++) cyc(0, 2'b00, 0, 0, 1, 2'b10, 1);
        exp_q = '{32'h20, 32'h21, 32'h22, 32'h23};
        chk_seq("mask_seq");
        // enable off, then reset mid-stream
        for (int i = 0; i < 3; i++) cyc(0, 2'b11, 32'h30 + i, 32'h40 + i, 0, 2'b11, 1);
        chk("en_no_output", got.size(), 0);
        cyc(1, 2'b00, 0, 0, 1, 2'b11, 1);
        for (int i = 0; i < 4; i++) cyc(0, 2'b00, 0, 0, 1, 2'b11, 1);
        chk("rst_discard", got.size(), 0);
        got.delete();
        // random traffic
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(63) == 0, 2'($urandom), $urandom, $urandom,
                $urandom_range(7) != 0, 2'($urandom), $urandom_range(3) != 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/collect_2x1_rr_seq.md
# collect_2x1_rr_seq

Two-input collect switch: the converging counterpart of the 1x2 distribute switch in the accelerator NoC. It accepts two independent input streams (low and high branch), buffers each in a small FIFO, and merges them onto a single registered output. Round-robin arbitration is used when both branches are eligible. The output carries a valid/ready handshake and a source tag, so downstream reduction or collection trees can apply backpressure.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width per branch
- FIFO_DEPTH, 4, entries per input FIFO; power of two, ≥2
- COMMAND_WIDTH, 2, width of i_cmd

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_valid  in  2  per-branch input valid, {high, low}
- i_data_bus  in  2*DATA_WIDTH  {i_data_high, i_data_low}
- o_ready  out  2  per-branch "FIFO not full", {high, low}
- o_valid  out  1  output word valid
- o_data_bus  out  DATA_WIDTH  merged output word
- o_src  out  1  branch of current output word: 0=low, 1=high
- i_ready  in  1  downstream accepts output
- i_en  in  1  enables arbitration/pop
- i_cmd  in  COMMAND_WIDTH  branch eligibility mask: 00 none, 01 low only, 10 high only, 11 both (round-robin)

## Operation
- Push: branch k writes its FIFO when i_valid[k] & o_ready[k]. A push ignores i_en and i_cmd.
- o_ready[k] = ~full[k]. It is driven from registered counts only, with no combinational path from i_ready.
- Eligible[k] = i_cmd[k] & FIFO k non-empty.
- Output transfer occurs when o_valid & i_ready, regardless of i_en.
- Load condition: i_en & (~o_valid | i_ready) & any eligible.
  - The granted FIFO head is popped into the output register, which sets o_valid=1, o_data_bus=head and o_src=k.
- If a transfer occurs and there is no load, o_valid goes to 0 and o_data_bus/o_src hold.
- Arbitration:
  - One eligible branch: it wins.
  - Both eligible: the branch not granted last wins.
  - The last_grant pointer updates only on a load. Its reset value is 1, so low wins the first tie.
- i_en=0: no pops and no loads. The output register holds; a pending word may still transfer.
- i_cmd masking: data in a masked FIFO is retained, never dropped. It drains once unmasked.
- Reset (sync, any cycle, including mid-transfer):
  - Both FIFOs are emptied and last_grant is set to 1.
  - o_valid=0, o_data_bus=0, o_src=0.
  - o_ready=2'b00 while rst=1, and 2'b11 the first cycle after rst deasserts.
  - Buffered data is discarded.
- Per-branch ordering is preserved. There is no ordering guarantee across branches.

## Timing
- Latency: a word pushed at edge t is popped at edge t+1 and visible on o_valid/o_data_bus in cycle t+2 (minimum 2 cycles).
- Throughput: 1 word/cycle sustained with i_ready=1. Back-to-back loads happen with no bubble.
- Simultaneous push and pop on the same FIFO in one cycle: both occur, and the count is unchanged.
- Push to an empty FIFO plus a pop in the same cycle cannot occur; a pop requires non-empty.
- Full FIFO: o_ready[k]=0, and a push attempt is ignored by the switch; the upstream must hold the word.
- Capacity per branch under backpressure: FIFO_DEPTH + 1 words, counting the output register.
- Pointer wrap-around: read/write pointers are log2(FIFO_DEPTH) bits. Full and empty are distinguished by a count of log2(FIFO_DEPTH)+1 bits.
- Output stability: while o_valid & ~i_ready, o_data_bus and o_src are held constant.

## Structure
- Shared package holds the command encodings:
  - CMD_NONE=2'b00, CMD_LOW=2'b01, CMD_HIGH=2'b10, CMD_BOTH=2'b11
  - SRC_LOW=1'b0, SRC_HIGH=1'b1
- Sub-module sync_fifo_simple_seq (DATA_WIDTH, FIFO_DEPTH; ports push, pop, din, dout, full, empty, sync active-high rst) is instantiated twice, once per branch.
- The arbiter and output register live in the top module.

## Test plan
- Reset: hold rst 2 cycles with i_valid=11 → o_valid=0, o_data_bus=0, o_src=0, o_ready=00; after release o_ready=11 and nothing is output.
- Single branch: i_cmd=01, i_en=1, i_ready=1, push 0xA on low at cycle 0 → cycle 2 shows o_valid=1, o_data_bus=0xA, o_src=0 for exactly one cycle.
- Round-robin: i_cmd=11, push low 1,2,3 and high 0x11,0x12,0x13 on the same cycles, i_ready=1 → output 1,0x11,2,0x12,3,0x13 back-to-back, o_src alternating 0,1.
- Backpressure: FIFO_DEPTH=4, i_ready=0, push low words 0..5 on cycles 0..5 → words 0–4 accepted, o_ready[0]=0 from cycle 5; word 0 held on the output; then i_ready=1 → 0,1,2,3,4 drained in order.
- Masking: i_cmd=01 with words queued on high → no high word is output and o_ready[1] falls after FIFO_DEPTH+0 pushes; switch to i_cmd=10 → high words drain in order.
- Enable and mid-reset: i_en=0 with both FIFOs non-empty → no new output loads; then assert rst for one cycle mid-stream → all buffered words discarded, o_valid=0 the next cycle.
